// File: rtl/lr_sum_accum_pkg.sv
// ---------------------------------------------------------------------------
// lr_sum_accum_pkg
//   Shared definitions for the linear-regression sum accumulator slice:
//   default datapath widths (shared with the sample memory and slope stage)
//   and the sequencer state encodings (3 bits, legacy-compatible values).
// ---------------------------------------------------------------------------
package lr_sum_accum_pkg;

  localparam int unsigned LR_DATA_W = 8;
  localparam int unsigned LR_ADDR_W = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AX   = 3'd1;
  localparam logic [2:0] ST_AY   = 3'd2;
  localparam logic [2:0] ST_ACC  = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  function automatic bit lr_is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/lr_mac.sv
// ---------------------------------------------------------------------------
// lr_mac
//   Unsigned multiply-accumulate: acc += a*b when en_i, acc <= 0 when clr_i
//   (clear wins). The full-width product is zero-extended to ACC_W before
//   the add. ACC_W must be at least 2*IN_W.
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   clr_i       synchronous clear of the accumulator
//   en_i        accumulate a_i*b_i this cycle
//   a_i, b_i    IN_W-bit unsigned operands
//   acc_o       ACC_W-bit accumulator value
// ---------------------------------------------------------------------------
module lr_mac #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ACC_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [IN_W-1:0]   a_i,
  input  logic [IN_W-1:0]   b_i,
  output logic [ACC_W-1:0]  acc_o
);

  logic [2*IN_W-1:0] prod;
  logic [ACC_W-1:0]  acc_q, acc_d;

  always_comb begin
    prod  = (2*IN_W)'(a_i) * (2*IN_W)'(b_i);
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/lr_sum_accum.sv
// ---------------------------------------------------------------------------
// lr_sum_accum
//   Read-side sequencer and accumulator. On an accepted start it reads
//   N_SAMPLES (x,y) pairs (x_i at address 2i, y_i at 2i+1, read data valid one
//   cycle after the address) and accumulates Sx, Sy, Sxy, Sxx. A one-cycle
//   done pulse marks the sums final; they hold until the next accepted start.
//   Sequence per pair: AX (addr 2i), AY (addr 2i+1, latch x), ACC (add).
// Ports
//   clk, rst_n      clock, asynchronous active-low reset (aborts a run)
//   start           begin a run; sampled only in IDLE
//   mem_addr        memory read address (holds when idle, 0 after reset)
//   mem_wr          memory write enable, constant 0
//   mem_rdata       memory read data
//   busy            high from start accept until done
//   done            one-cycle pulse, sums final
//   sum_x, sum_y    DATA_W+CNT_W sums
//   sum_xy, sum_xx  2*DATA_W+CNT_W sums
// Optional feature (macro LR_MEAN_EN)
//   mean_x, mean_y  Sx, Sy >> log2(N_SAMPLES), valid with done;
//                   N_SAMPLES must then be a power of two.
// ---------------------------------------------------------------------------
module lr_sum_accum
  import lr_sum_accum_pkg::*;
#(
  parameter int unsigned DATA_W    = LR_DATA_W,
  parameter int unsigned ADDR_W    = LR_ADDR_W,
  parameter int unsigned N_SAMPLES = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_wr,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_W+CNT_W-1:0]   sum_x,
  output logic [DATA_W+CNT_W-1:0]   sum_y,
  output logic [2*DATA_W+CNT_W-1:0] sum_xy,
  output logic [2*DATA_W+CNT_W-1:0] sum_xx
`ifdef LR_MEAN_EN
  ,
  output logic [DATA_W-1:0]         mean_x,
  output logic [DATA_W-1:0]         mean_y
`endif
);

  localparam int unsigned SUM_W = DATA_W + CNT_W;
  localparam int unsigned PRD_W = 2 * DATA_W + CNT_W;
  // Pair index needs at least one bit even when N_SAMPLES=1 permits CNT_W=0.
  localparam int unsigned IDX_W = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [SUM_W-1:0]  sx_q, sx_d, sy_q, sy_d;
  logic              mac_clr, mac_en;

  assign cnt_inc = cnt_q + IDX_W'(1);

  // mem_addr is a register loaded one state ahead so that it shows 2i in AX
  // and 2i+1 in AY, and simply holds outside a run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    x_d     = x_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mac_clr = 1'b1;
          cnt_d   = '0;
          sx_d    = '0;
          sy_d    = '0;
          addr_d  = '0;
          state_d = ST_AX;
        end
      end
      ST_AX: begin
        addr_d  = ADDR_W'({cnt_q, 1'b1});
        state_d = ST_AY;
      end
      ST_AY: begin
        x_d     = mem_rdata;
        state_d = ST_ACC;
      end
      ST_ACC: begin
        mac_en = 1'b1;
        sx_d   = sx_q + SUM_W'(x_q);
        sy_d   = sy_q + SUM_W'(mem_rdata);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_FIN;
        end else begin
          cnt_d   = cnt_inc;
          addr_d  = ADDR_W'({cnt_inc, 1'b0});
          state_d = ST_AX;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      x_q     <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

  lr_mac #(
    .IN_W  (DATA_W),
    .ACC_W (PRD_W)
  ) u_mac_xy (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (x_q),
    .b_i   (mem_rdata),
    .acc_o (sum_xy)
  );

  lr_mac #(
    .IN_W  (DATA_W),
    .ACC_W (PRD_W)
  ) u_mac_xx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (x_q),
    .b_i   (x_q),
    .acc_o (sum_xx)
  );

  assign mem_addr = addr_q;
  assign mem_wr   = 1'b0;
  assign busy     = (state_q == ST_AX) || (state_q == ST_AY) || (state_q == ST_ACC);
  assign done     = (state_q == ST_FIN);
  assign sum_x    = sx_q;
  assign sum_y    = sy_q;

`ifdef LR_MEAN_EN
  localparam int unsigned MEAN_SH = $clog2(N_SAMPLES);

  generate
    if (!lr_is_pow2(N_SAMPLES)) begin : g_bad_n
      $error("lr_sum_accum: N_SAMPLES must be a power of two when LR_MEAN_EN is defined");
    end
  endgenerate

  logic [DATA_W-1:0] mean_x_q, mean_y_q;

  // Loaded from the final next-state sums on the ACC->FIN edge so the means
  // are already valid in the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mean_x_q <= '0;
      mean_y_q <= '0;
    end else if (state_q == ST_ACC && cnt_q == LAST_IDX) begin
      mean_x_q <= DATA_W'(sx_d >> MEAN_SH);
      mean_y_q <= DATA_W'(sy_d >> MEAN_SH);
    end
  end

  assign mean_x = mean_x_q;
  assign mean_y = mean_y_q;
`endif

endmodule

// File: tb/tb_lr_sum_accum.sv
// ---------------------------------------------------------------------------
// tb_lr_sum_accum
//   Scoreboard bench for lr_sum_accum: a registered-read memory model feeds
//   the DUT; expected sums are computed from the memory contents when start
//   is accepted, queued, and compared when done pulses. Compile with
//   +define+LR_MEAN_EN to also cover mean_x/mean_y.
// ---------------------------------------------------------------------------
module tb_lr_sum_accum;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned N      = 4;
  localparam int unsigned CNT_W  = 3;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      start = 1'b0;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_wr;
  logic [DATA_W-1:0]         mem_rdata = '0;
  logic                      busy;
  logic                      done;
  logic [DATA_W+CNT_W-1:0]   sum_x, sum_y;
  logic [2*DATA_W+CNT_W-1:0] sum_xy, sum_xx;
`ifdef LR_MEAN_EN
  logic [DATA_W-1:0]         mean_x, mean_y;
`endif

  lr_sum_accum #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .N_SAMPLES (N),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .sum_x     (sum_x),
    .sum_y     (sum_y),
    .sum_xy    (sum_xy),
    .sum_xx    (sum_xx)
`ifdef LR_MEAN_EN
    ,
    .mean_x    (mean_x),
    .mean_y    (mean_y)
`endif
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  int unsigned mem_wr_hits = 0;
  always @(negedge clk) if (mem_wr !== 1'b0) mem_wr_hits++;

  typedef struct {
    logic [63:0] sx, sy, sxy, sxx, mx, my;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    e.sx = 0; e.sy = 0; e.sxy = 0; e.sxx = 0;
    for (int i = 0; i < int'(N); i++) begin
      logic [63:0] x, y;
      x = 64'(mem[2*i]);
      y = 64'(mem[2*i+1]);
      e.sx  += x;
      e.sy  += y;
      e.sxy += x * y;
      e.sxx += x * x;
    end
    e.mx = e.sx >> $clog2(N);
    e.my = e.sy >> $clog2(N);
    return e;
  endfunction

  task automatic load_lin();
    for (int i = 0; i < int'(N); i++) begin
      mem[2*i]   = DATA_W'(i + 1);
      mem[2*i+1] = DATA_W'(2 * (i + 1));
    end
  endtask

  // Called #1 after a rising edge with the DUT idle. extra_cyc: cycle of the
  // run in which start is re-pulsed; abort_cyc: cycle in which rst_n drops;
  // hold: keep start high from the done cycle to chain the next run.
  task automatic run(input int extra_cyc, input bit trace_chk, input int abort_cyc, input bit hold);
    exp_t e, got_e;
    int cyc;
    int dn;
    logic [ADDR_W-1:0] tr[$];
    check_eq("idle_before_start", busy, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    sb.push_back(model());
    check_eq("busy_after_accept", busy, 1'b1);
    while (!done && cyc < int'(3*N) + 20) begin
      tr.push_back(mem_addr);
      start = (cyc == extra_cyc);
      if (cyc == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_addr", mem_addr, 0);
        check_eq("abort_sums", {sum_x, sum_y, sum_xy, sum_xx}, 0);
        void'(sb.pop_back());
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        dn = 0;
        repeat (20) begin
          @(posedge clk); #1;
          if (done) dn++;
        end
        check_eq("no_done_after_abort", dn, 0);
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check_eq("done_seen", done, 1'b1);
    check_eq("done_latency", cyc, 3*N + 1);
    check_eq("busy_at_done", busy, 1'b0);
    if (done && sb.size() > 0) begin
      got_e = sb.pop_front();
      check_eq("sum_x", sum_x, got_e.sx);
      check_eq("sum_y", sum_y, got_e.sy);
      check_eq("sum_xy", sum_xy, got_e.sxy);
      check_eq("sum_xx", sum_xx, got_e.sxx);
`ifdef LR_MEAN_EN
      check_eq("mean_x", mean_x, got_e.mx);
      check_eq("mean_y", mean_y, got_e.my);
`endif
    end else begin
      check_eq("scoreboard_entry", sb.size(), 1);
      got_e = model();
    end
    if (trace_chk) begin
      check_eq("trace_len", tr.size(), 3*N);
      for (int k = 0; k < tr.size() && k < int'(3*N); k++) begin
        int pi, ea;
        pi = k / 3;
        ea = (k % 3 == 0) ? 2*pi : 2*pi + 1;
        check_eq($sformatf("addr_trace[%0d]", k), tr[k], ea);
      end
    end
    if (hold) start = 1'b1;
    @(posedge clk); #1;
    check_eq("done_one_cycle", done, 1'b0);
    check_eq("idle_after_fin", busy, 1'b0);
    check_eq("sum_x_hold", sum_x, got_e.sx);
    check_eq("sum_xy_hold", sum_xy, got_e.sxy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_done", done, 1'b0);
    check_eq("reset_addr", mem_addr, 0);
    check_eq("reset_sums", {sum_x, sum_y, sum_xy, sum_xx}, 0);
`ifdef LR_MEAN_EN
    check_eq("reset_means", {mean_x, mean_y}, 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Linear data with address trace
    load_lin();
    run(-1, 1'b1, -1, 1'b0);

    // All-ones data: widest sums
    for (int i = 0; i < 2*int'(N); i++) mem[i] = '1;
    run(-1, 1'b0, -1, 1'b0);

    // Ignored start mid-run, start held through FIN, back-to-back rerun
    load_lin();
    run(5, 1'b0, -1, 1'b1);
    run(-1, 1'b0, -1, 1'b0);

    // Abort by reset, then a clean run
    run(-1, 1'b0, 7, 1'b0);
    run(-1, 1'b0, -1, 1'b0);

    // Random data
    for (int i = 0; i < 2*int'(N); i++) mem[i] = DATA_W'($urandom_range(0, 255));
    run(-1, 1'b0, -1, 1'b0);

    check_eq("mem_wr_never_high", mem_wr_hits, 0);
    check_eq("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
